// File: rtl/dual_port_ram_be_clr_pkg.sv
// Shared definitions for the dual-port lane-enabled RAM with clear engine:
// read-during-write selectors and the clear FSM state encoding.
package dual_port_ram_be_clr_pkg;

    localparam int unsigned RDW_OLD = 32'd0;
    localparam int unsigned RDW_NEW = 32'd1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/dual_port_ram_be_clr_if.sv
// Bus bundle for the dual-port RAM: port A R/W with lane enables, port B read,
// clear request and busy status.
interface dual_port_ram_be_clr_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANE_WIDTH = 8
);
    localparam int unsigned NLANES = DATA_WIDTH / LANE_WIDTH;

    logic                  we_a;
    logic [NLANES-1:0]     be_a;
    logic                  re_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] dout_a;
    logic                  rvalid_a;
    logic                  re_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] dout_b;
    logic                  rvalid_b;
    logic                  clr_req;
    logic                  busy;

    modport master (
        output we_a, be_a, re_a, addr_a, din_a, re_b, addr_b, clr_req,
        input  dout_a, rvalid_a, dout_b, rvalid_b, busy
    );

    modport slave (
        input  we_a, be_a, re_a, addr_a, din_a, re_b, addr_b, clr_req,
        output dout_a, rvalid_a, dout_b, rvalid_b, busy
    );
endinterface

// File: rtl/dual_port_ram_be_clr_array.sv
// Storage array: one write port with lane enables, two synchronous read-first
// read ports whose data registers hold between reads.
module dual_port_ram_be_clr_array #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANE_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 we,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]     be,
    input  logic [ADDR_WIDTH-1:0]                waddr,
    input  logic [DATA_WIDTH-1:0]                wdata,
    input  logic                                 re_a,
    input  logic [ADDR_WIDTH-1:0]                raddr_a,
    output logic [DATA_WIDTH-1:0]                rdata_a,
    input  logic                                 re_b,
    input  logic [ADDR_WIDTH-1:0]                raddr_b,
    output logic [DATA_WIDTH-1:0]                rdata_b
);
    localparam int unsigned NLANES = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned DEPTH  = 32'd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_a_q;
    logic [DATA_WIDTH-1:0] rdata_b_q;

    // Lane-masked write; contents are never reset.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NLANES; l++) begin
            if (we && be[l]) begin
                mem[waddr][l*LANE_WIDTH +: LANE_WIDTH] <= wdata[l*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // Read registers sample the pre-write word, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (re_a) begin
                rdata_a_q <= mem[raddr_a];
            end
            if (re_b) begin
                rdata_b_q <= mem[raddr_b];
            end
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
endmodule

// File: rtl/dual_port_ram_be_clr.sv
// Dual-port frame/char RAM top: clear sweep FSM, write mux (sweep vs port A),
// read-during-write bypass for port B, optional output stage and valid strobes.
module dual_port_ram_be_clr
    import dual_port_ram_be_clr_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = 6,
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter int unsigned           LANE_WIDTH     = 8,
    parameter bit                    OUT_REG        = 1'b0,
    parameter int unsigned           RDW_MODE       = RDW_NEW,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    dual_port_ram_be_clr_if.slave bus
);
    localparam int unsigned NLANES = DATA_WIDTH / LANE_WIDTH;

    if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_cfg
        $fatal(1, "DATA_WIDTH must be an integer multiple of LANE_WIDTH");
    end

    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NLANES-1:0]     be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int l = 0; l < NLANES; l++) begin
            if (be[l]) begin
                r[l*LANE_WIDTH +: LANE_WIDTH] = new_w[l*LANE_WIDTH +: LANE_WIDTH];
            end else begin
                r[l*LANE_WIDTH +: LANE_WIDTH] = old_w[l*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        return r;
    endfunction

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic                  start_s, busy_s;
    logic                  wr_a_s, re_a_ok_s, re_b_ok_s, byp_hit_s;
    logic                  mem_we_s;
    logic [NLANES-1:0]     mem_be_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic [DATA_WIDTH-1:0] rdata_a_s, rdata_b_s, dout_b1_s;
    logic                  rv_a_q, rv_b_q, byp_q;
    logic [DATA_WIDTH-1:0] byp_din_q;
    logic [NLANES-1:0]     byp_be_q;

    // Clear FSM state; pend_q remembers that a post-reset sweep is owed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Clear FSM next state: one word per cycle, leave after the last address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q || bus.clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Access qualification and write-port mux; a starting sweep drops port A's write.
    always_comb begin
        busy_s    = (state_q == ST_CLEAR);
        wr_a_s    = bus.we_a && !busy_s && !start_s && !reset;
        re_a_ok_s = bus.re_a && !busy_s;
        re_b_ok_s = bus.re_b && !busy_s;
        byp_hit_s = (RDW_MODE == RDW_NEW) && wr_a_s && re_b_ok_s && (bus.addr_a == bus.addr_b);
        if (busy_s) begin
            mem_we_s    = !reset;
            mem_be_s    = '1;
            mem_addr_s  = cnt_q;
            mem_wdata_s = CLEAR_VALUE;
        end else begin
            mem_we_s    = wr_a_s;
            mem_be_s    = bus.be_a;
            mem_addr_s  = bus.addr_a;
            mem_wdata_s = bus.din_a;
        end
    end

    dual_port_ram_be_clr_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_WIDTH (LANE_WIDTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we_s),
        .be      (mem_be_s),
        .waddr   (mem_addr_s),
        .wdata   (mem_wdata_s),
        .re_a    (re_a_ok_s),
        .raddr_a (bus.addr_a),
        .rdata_a (rdata_a_s),
        .re_b    (re_b_ok_s),
        .raddr_b (bus.addr_b),
        .rdata_b (rdata_b_s)
    );

    // First-stage valids and the captured write that port B's result must overlay.
    always_ff @(posedge clk) begin
        if (reset) begin
            rv_a_q    <= 1'b0;
            rv_b_q    <= 1'b0;
            byp_q     <= 1'b0;
            byp_din_q <= '0;
            byp_be_q  <= '0;
        end else begin
            rv_a_q <= re_a_ok_s;
            rv_b_q <= re_b_ok_s;
            if (re_b_ok_s) begin
                byp_q     <= byp_hit_s;
                byp_din_q <= bus.din_a;
                byp_be_q  <= bus.be_a;
            end
        end
    end

    // Port B stage-1 data: read-first word, optionally overlaid with the colliding write.
    always_comb begin
        if (byp_q) begin
            dout_b1_s = lane_merge(rdata_b_s, byp_din_q, byp_be_q);
        end else begin
            dout_b1_s = rdata_b_s;
        end
    end

    if (OUT_REG) begin : g_oreg
        logic [DATA_WIDTH-1:0] dout_a_q, dout_b_q;
        logic                  rv_a2_q, rv_b2_q;

        // Extra output stage; data only advances with a valid so it holds between reads.
        always_ff @(posedge clk) begin
            if (reset) begin
                dout_a_q <= '0;
                dout_b_q <= '0;
                rv_a2_q  <= 1'b0;
                rv_b2_q  <= 1'b0;
            end else begin
                rv_a2_q <= rv_a_q;
                rv_b2_q <= rv_b_q;
                if (rv_a_q) begin
                    dout_a_q <= rdata_a_s;
                end
                if (rv_b_q) begin
                    dout_b_q <= dout_b1_s;
                end
            end
        end

        assign bus.dout_a   = dout_a_q;
        assign bus.rvalid_a = rv_a2_q;
        assign bus.dout_b   = dout_b_q;
        assign bus.rvalid_b = rv_b2_q;
    end else begin : g_noreg
        assign bus.dout_a   = rdata_a_s;
        assign bus.rvalid_a = rv_a_q;
        assign bus.dout_b   = dout_b1_s;
        assign bus.rvalid_b = rv_b_q;
    end

    assign bus.busy = busy_s;
endmodule

// File: tb/tb_dual_port_ram_be_clr.sv
// Directed bench: two instances (latency 1 / new-data RDW, latency 2 / old-data RDW)
// driven by one shared stimulus stream.
module tb_dual_port_ram_be_clr;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;
    localparam logic [31:0] CV = 32'hA5A5_A5A5;

    logic        clk;
    logic        reset;
    logic        we_a, re_a, re_b, clr_req;
    logic [3:0]  be_a;
    logic [5:0]  addr_a, addr_b;
    logic [31:0] din_a;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          n, m;

    dual_port_ram_be_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW)) if0 ();
    dual_port_ram_be_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW)) if1 ();

    assign if0.we_a = we_a;     assign if1.we_a = we_a;
    assign if0.be_a = be_a;     assign if1.be_a = be_a;
    assign if0.re_a = re_a;     assign if1.re_a = re_a;
    assign if0.addr_a = addr_a; assign if1.addr_a = addr_a;
    assign if0.din_a = din_a;   assign if1.din_a = din_a;
    assign if0.re_b = re_b;     assign if1.re_b = re_b;
    assign if0.addr_b = addr_b; assign if1.addr_b = addr_b;
    assign if0.clr_req = clr_req; assign if1.clr_req = clr_req;

    dual_port_ram_be_clr #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW), .OUT_REG(1'b0),
        .RDW_MODE(32'd1), .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)
    ) u_dut0 (.clk(clk), .reset(reset), .bus(if0));

    dual_port_ram_be_clr #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW), .OUT_REG(1'b1),
        .RDW_MODE(32'd0), .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)
    ) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; we_a = 1'b0; re_a = 1'b0; re_b = 1'b0; clr_req = 1'b0;
        be_a = 4'h0; addr_a = 6'd0; addr_b = 6'd0; din_a = 32'h0;
        repeat (3) tick();
        chk1("rst_busy0", if0.busy, 1'b0);
        chk1("rst_busy1", if1.busy, 1'b0);
        chk1("rst_rva0", if0.rvalid_a, 1'b0);
        chk1("rst_rvb1", if1.rvalid_b, 1'b0);
        chk32("rst_douta0", if0.dout_a, 32'h0);
        chk32("rst_doutb1", if1.dout_b, 32'h0);

        // Test 1: automatic sweep after reset release, then read back everything
        reset = 1'b0;
        tick();
        chk1("t1_busy_rise", if0.busy, 1'b1);
        n = 0; m = 0;
        while (if0.busy === 1'b1 && n < 200) begin
            n++;
            if (if1.busy === 1'b1) m++;
            tick();
        end
        chk32("t1_sweep_len0", 32'(n), 32'd64);
        chk32("t1_sweep_len1", 32'(m), 32'd64);
        for (int i = 0; i < 64; i++) begin
            re_a = 1'b1; addr_a = 6'(i); re_b = 1'b1; addr_b = 6'(63 - i);
            tick();
            chk32("t1_rd_b0", if0.dout_b, CV);
            chk1("t1_rv_b0", if0.rvalid_b, 1'b1);
            chk32("t1_rd_a0", if0.dout_a, CV);
            if (i > 0) begin
                chk32("t1_rd_b1", if1.dout_b, CV);
                chk1("t1_rv_b1", if1.rvalid_b, 1'b1);
            end else begin
                chk1("t1_rv_b1_lat", if1.rvalid_b, 1'b0);
            end
        end
        re_a = 1'b0; re_b = 1'b0;
        tick();
        chk1("t1_rv_b0_end", if0.rvalid_b, 1'b0);
        chk1("t1_rv_b1_end", if1.rvalid_b, 1'b1);
        chk32("t1_rd_b1_end", if1.dout_b, CV);
        tick();

        // Test 2: lane-enabled writes, be=0 no-op, read latency and hold
        we_a = 1'b1; addr_a = 6'd5; be_a = 4'b1111; din_a = 32'h1122_3344;
        tick();
        be_a = 4'b0010; din_a = 32'hFFFF_FFFF;
        tick();
        be_a = 4'b0000; din_a = 32'h0;
        tick();
        we_a = 1'b0; re_a = 1'b1;
        tick();
        re_a = 1'b0;
        chk32("t2_a0", if0.dout_a, 32'h1122_FF44);
        chk1("t2_rva0", if0.rvalid_a, 1'b1);
        chk1("t2_rva1_early", if1.rvalid_a, 1'b0);
        tick();
        chk32("t2_a1", if1.dout_a, 32'h1122_FF44);
        chk1("t2_rva1", if1.rvalid_a, 1'b1);
        chk1("t2_rva0_pulse", if0.rvalid_a, 1'b0);
        chk32("t2_hold0", if0.dout_a, 32'h1122_FF44);

        // Test 3: back-to-back port B reads
        be_a = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            we_a = 1'b1; addr_a = 6'(i); din_a = 32'h1000_0000 + 32'(i);
            tick();
        end
        we_a = 1'b0;
        for (int k = 0; k < 6; k++) begin
            re_b = (k < 4); addr_b = 6'(k);
            tick();
            chk1("t3_rv0", if0.rvalid_b, (k < 4));
            if (k < 4) chk32("t3_d0", if0.dout_b, 32'h1000_0000 + 32'(k));
            chk1("t3_rv1", if1.rvalid_b, (k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) chk32("t3_d1", if1.dout_b, 32'h1000_0000 + 32'(k - 1));
        end
        re_b = 1'b0;

        // Test 4: read-during-write on the same address, then independence and port A read-first
        we_a = 1'b1; addr_a = 6'd9; be_a = 4'b1111; din_a = 32'h0;
        tick();
        be_a = 4'b1100; din_a = 32'hDEAD_BEEF; re_b = 1'b1; addr_b = 6'd9;
        tick();
        we_a = 1'b0; re_b = 1'b0;
        chk32("t4_rdw_new", if0.dout_b, 32'hDEAD_0000);
        tick();
        chk32("t4_rdw_old", if1.dout_b, 32'h0);
        chk1("t4_rdw_old_rv", if1.rvalid_b, 1'b1);
        we_a = 1'b1; addr_a = 6'd10; be_a = 4'b1111; din_a = 32'h0102_0304; re_b = 1'b1; addr_b = 6'd9;
        tick();
        we_a = 1'b0; re_b = 1'b0;
        chk32("t4_diff_addr0", if0.dout_b, 32'hDEAD_0000);
        tick();
        chk32("t4_diff_addr1", if1.dout_b, 32'hDEAD_0000);
        we_a = 1'b1; addr_a = 6'd9; din_a = 32'h1234_5678; re_a = 1'b1;
        tick();
        we_a = 1'b0; re_a = 1'b0;
        chk32("t4_a_rfirst0", if0.dout_a, 32'hDEAD_0000);
        tick();
        chk32("t4_a_rfirst1", if1.dout_a, 32'hDEAD_0000);
        re_a = 1'b1;
        tick();
        re_a = 1'b0;
        chk32("t4_a_new0", if0.dout_a, 32'h1234_5678);
        tick();
        chk32("t4_a_new1", if1.dout_a, 32'h1234_5678);

        // Test 5: requested sweep; second request and accesses while busy are ignored
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk1("t5_busy_rise", if0.busy, 1'b1);
        n = 0;
        while (if0.busy === 1'b1 && n < 200) begin
            n++;
            if (n == 21) begin
                clr_req = 1'b1; we_a = 1'b1; addr_a = 6'd5; be_a = 4'b1111;
                din_a = 32'h7777_7777; re_a = 1'b1; re_b = 1'b1; addr_b = 6'd7;
            end else begin
                clr_req = 1'b0; we_a = 1'b0; re_a = 1'b0; re_b = 1'b0;
            end
            tick();
            if (n == 21) begin
                chk1("t5_busy_rvb0", if0.rvalid_b, 1'b0);
                chk1("t5_busy_rva0", if0.rvalid_a, 1'b0);
            end
            if (n == 22) chk1("t5_busy_rvb1", if1.rvalid_b, 1'b0);
        end
        clr_req = 1'b0; we_a = 1'b0; re_a = 1'b0; re_b = 1'b0;
        chk32("t5_sweep_len", 32'(n), 32'd64);
        re_b = 1'b1; addr_b = 6'd5; re_a = 1'b1; addr_a = 6'd9;
        tick();
        re_b = 1'b0; re_a = 1'b0;
        chk32("t5_nowrite0", if0.dout_b, CV);
        chk32("t5_cleared0", if0.dout_a, CV);
        tick();
        chk32("t5_nowrite1", if1.dout_b, CV);

        // Test 6: reset mid-sweep aborts it and a fresh sweep follows release
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (30) tick();
        chk1("t6_busy_mid", if0.busy, 1'b1);
        reset = 1'b1; re_a = 1'b1; re_b = 1'b1; addr_b = 6'd3;
        tick();
        chk1("t6_rst_busy0", if0.busy, 1'b0);
        chk1("t6_rst_busy1", if1.busy, 1'b0);
        chk1("t6_rst_rvb0", if0.rvalid_b, 1'b0);
        chk32("t6_rst_dout0", if0.dout_b, 32'h0);
        chk32("t6_rst_dout1", if1.dout_a, 32'h0);
        tick();
        chk1("t6_rst_rvb1", if1.rvalid_b, 1'b0);
        chk1("t6_rst_rva0", if0.rvalid_a, 1'b0);
        re_a = 1'b0; re_b = 1'b0; reset = 1'b0;
        tick();
        chk1("t6_busy_rise", if0.busy, 1'b1);
        n = 0;
        while (if0.busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk32("t6_sweep_len", 32'(n), 32'd64);
        re_b = 1'b1; addr_b = 6'd3;
        tick();
        re_b = 1'b0;
        chk32("t6_cleared0", if0.dout_b, CV);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
